// File: rtl/shift_pkg.sv
// Shared types for the sequential shifter.
//   op_e    : operation codes carried on in_op (values 5-7 are reserved)
//   state_e : controller states
//   op_legal: true for the five defined operations
package shift_pkg;

    typedef enum logic [2:0] {
        OP_LSL  = 3'd0,
        OP_LSR  = 3'd1,
        OP_ASR  = 3'd2,
        OP_ROTL = 3'd3,
        OP_ROTR = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One 1-bit shift/rotate step.
//   x    : current value
//   op   : operation; reserved codes pass x through
//   y    : value after one step
//   bout : the bit that left the vector on this step (0 for reserved ops)
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  op_e              op,
    output logic [WIDTH-1:0] y,
    output logic             bout
);

    always_comb begin
        y    = x;
        bout = 1'b0;
        case (op)
            OP_LSL:  begin y = {x[WIDTH-2:0], 1'b0};       bout = x[WIDTH-1]; end
            OP_LSR:  begin y = {1'b0, x[WIDTH-1:1]};       bout = x[0];       end
            OP_ASR:  begin y = {x[WIDTH-1], x[WIDTH-1:1]}; bout = x[0];       end
            OP_ROTL: begin y = {x[WIDTH-2:0], x[WIDTH-1]}; bout = x[WIDTH-1]; end
            OP_ROTR: begin y = {x[0], x[WIDTH-1:1]};       bout = x[0];       end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Sequential shifter/rotator: one bit position per cycle.
// Build option: SHIFT_SEQ_CARRY_EN adds out_carry (last bit shifted out).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : command handshake; ready only while idle
//   in_data/in_op/in_amt: operand, operation code, step count
//   out_valid/out_ready : result handshake; result held until taken
//   out_data            : result
//   out_carry           : (SHIFT_SEQ_CARRY_EN only) last bit out, 0 if no step
// Latency from accept to out_valid is amt+1 cycles; amt=0 and reserved ops
// take 1 cycle and return the operand unchanged.
module shift_seq_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SHIFT_SEQ_CARRY_EN
    output logic             out_carry,
`endif
    output logic [WIDTH-1:0] out_data
);

    state_e           state;
    op_e              op_q;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH-1:0] step_y;
    logic             step_c;

    // out_data doubles as the working register; it is only qualified by
    // out_valid, so intermediate values during SHIFT are harmless.
    shift_step #(.WIDTH(WIDTH)) u_step (
        .x    (out_data),
        .op   (op_q),
        .y    (step_y),
        .bout (step_c)
    );

`ifndef SHIFT_SEQ_CARRY_EN
    logic unused_carry;
    assign unused_carry = step_c;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            op_q      <= OP_LSL;
            cnt       <= '0;
`ifdef SHIFT_SEQ_CARRY_EN
            out_carry <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_data <= in_data;
                        op_q     <= op_e'(in_op);
                        cnt      <= in_amt;
                        in_ready <= 1'b0;
`ifdef SHIFT_SEQ_CARRY_EN
                        out_carry <= 1'b0;
`endif
                        if (in_amt != '0 && op_legal(in_op)) begin
                            state <= SHIFT;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    out_data <= step_y;
                    cnt      <= cnt - AMT_W'(1);
`ifdef SHIFT_SEQ_CARRY_EN
                    out_carry <= step_c;
`endif
                    if (cnt == AMT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // No accept in the handshake cycle: in_ready rises only
                    // once back in IDLE.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_unit.sv
module tb_shift_seq_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [2:0] in_op = '0;
    logic [2:0] in_amt = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
`ifdef SHIFT_SEQ_CARRY_EN
    logic       out_carry;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_seq_unit #(.WIDTH(8), .AMT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SHIFT_SEQ_CARRY_EN
        .out_carry (out_carry),
`endif
        .out_data  (out_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: whole shift in one arithmetic expression; returns {carry, data}.
    function automatic logic [8:0] model(input logic [7:0] d, input logic [2:0] op, input int a);
        logic [15:0] w;
        logic [7:0]  r;
        logic        c;
        if (op > 3'd4 || a == 0) return {1'b0, d};
        r = d;
        c = 1'b0;
        case (op)
            3'd0: begin r = 8'(d << a); c = d[8-a]; end
            3'd1: begin r = d >> a; c = d[a-1]; end
            3'd2: begin r = 8'($signed(d) >>> a); c = d[a-1]; end
            3'd3: begin w = {d, d} << a; r = w[15:8]; c = r[0]; end
            default: begin w = {d, d} >> a; r = w[7:0]; c = r[7]; end
        endcase
        return {c, r};
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
    task automatic do_cmd(input logic [7:0] d, input logic [2:0] op, input logic [2:0] amt,
                          input int hold);
        logic [8:0] exp;
        int         lat;
        int         exp_lat;
        exp     = model(d, op, int'(amt));
        exp_lat = (op <= 3'd4 && amt != 0) ? int'(amt) + 1 : 1;
        chk("idle_ready", in_ready, 1);
        in_valid = 1'b1; in_data = d; in_op = op; in_amt = amt;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk("busy_ready", in_ready, 0);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("data", out_data, exp[7:0]);
`ifdef SHIFT_SEQ_CARRY_EN
        chk("carry", out_carry, exp[8]);
`endif
        // Stall downstream; a new command must be ignored meanwhile.
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom); in_op = 3'($urandom); in_amt = 3'($urandom);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, exp[7:0]);
            chk("hold_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("drain_valid", out_valid, 0);
        chk("drain_ready", in_ready, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
`ifdef SHIFT_SEQ_CARRY_EN
        chk("rst_carry", out_carry, 0);
`endif

        do_cmd(8'h81, 3'd0, 3'd1, 0);   // LSL 1 -> 02
        do_cmd(8'h90, 3'd2, 3'd3, 0);   // ASR 3 -> F2
        do_cmd(8'h81, 3'd3, 3'd1, 0);   // ROTL 1 -> 03
        do_cmd(8'h81, 3'd4, 3'd1, 0);   // ROTR 1 -> C0
        do_cmd(8'h5A, 3'd6, 3'd5, 0);   // reserved -> passthrough
        do_cmd(8'h5A, 3'd1, 3'd0, 0);   // amt 0 -> passthrough
        do_cmd(8'hA5, 3'd4, 3'd7, 5);   // long stall in DONE
        do_cmd(8'hF0, 3'd0, 3'd7, 0);   // max amount
        do_cmd(8'h80, 3'd2, 3'd7, 0);   // sign fill to FF

        // Reset in the middle of a long shift.
        in_valid = 1'b1; in_data = 8'hC3; in_op = 3'd1; in_amt = 3'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", in_ready, 1);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
`ifdef SHIFT_SEQ_CARRY_EN
        chk("midrst_carry", out_carry, 0);
`endif
        do_cmd(8'h3C, 3'd1, 3'd2, 1);

        for (int n = 0; n < 60; n++)
            do_cmd(8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom),
                   int'($urandom_range(0, 2)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_seq_unit.md
SHIFT_SEQ_UNIT -- requirements
Module: shift_seq_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data vector width in bits.
REQ-002 SHALL have parameter AMT_W, default 3: shift-amount field width; legal amounts are 0..2^AMT_W-1.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  the upstream command is valid.
REQ-006 SHALL have port in_ready  output  1  the unit accepts a command this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  operand, signed two's complement.
REQ-008 SHALL have port in_op  input  3  operation: 0 LSL, 1 LSR, 2 ASR, 3 ROTL, 4 ROTR, 5-7 reserved.
REQ-009 SHALL have port in_amt  input  AMT_W  shift/rotate amount.
REQ-010 SHALL have port out_valid  output  1  the result is valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port out_data  output  WIDTH  the result.
REQ-013 SHALL have port out_carry  output  1  the last bit shifted or rotated out; present only under SHIFT_SEQ_CARRY_EN.

Function
REQ-014 SHALL implement an FSM with states IDLE, SHIFT and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL accept a command on in_valid&&in_ready, capturing in_data, in_op and in_amt into internal registers; the FSM then enters SHIFT if amt>0 and the op is legal, otherwise DONE.
REQ-016 SHALL, in SHIFT, apply exactly one 1-bit step per cycle and decrement the remaining count; when the count reaches 1, the FSM enters DONE after that step.
REQ-017 SHALL define the 1-bit steps for x as follows: LSL={x[W-2:0],0}; LSR={0,x[W-1:1]}; ASR={x[W-1],x[W-1:1]}; ROTL={x[W-2:0],x[W-1]}; ROTR={x[0],x[W-1:1]}.
REQ-018 SHALL produce out_valid exactly amt+1 cycles after the accept cycle (1 cycle for amt=0).
REQ-019 SHALL pass reserved ops (5-7) through unchanged with a latency of 1, exactly as amt=0.
REQ-020 SHALL hold out_data and out_valid stable in DONE until out_ready=1; on out_valid&&out_ready the FSM returns to IDLE on the next cycle, with no accept in the handshake cycle.
REQ-021 SHALL leave in_valid ignored outside IDLE, with no queuing.
REQ-022 SHALL treat a rotate of WIDTH positions (when reachable) as the identity on data.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, enter IDLE and set out_data=0, out_valid=0 and out_carry=0, with in_ready=1 on the following cycle.
REQ-024 SHALL let rst asserted during SHIFT or DONE abandon the operation, with no partial result presented.

Configuration
REQ-025 SHALL, with SHIFT_SEQ_CARRY_EN defined, present out_carry: the bit leaving position W-1 (LSL/ROTL) or position 0 (LSR/ASR/ROTR) on the final step, or 0 for amt=0 or reserved ops, held with out_data.
REQ-026 SHALL, without SHIFT_SEQ_CARRY_EN, omit the out_carry port and its register, leaving all other behaviour identical.

Structure
REQ-027 SHALL place the op-code enum (OP_LSL..OP_ROTR) and the FSM state typedef in the shared package shift_pkg.
REQ-028 SHALL instantiate one combinational sub-module, shift_step, that maps (x, op) to (step result, bit out) and is reused each SHIFT cycle.

Verification
REQ-029 SHALL cover: in_data=8'h81, op=LSL, amt=1 -> out_data=8'h02, carry=1, out_valid at cycle 2.
REQ-030 SHALL cover: in_data=8'h90, op=ASR, amt=3 -> out_data=8'hF2, carry=0, out_valid 4 cycles after accept.
REQ-031 SHALL cover: in_data=8'h81, op=ROTL then ROTR, amt=1 -> 8'h03 then 8'hC0, carry=1 both.
REQ-032 SHALL cover: op=6 or amt=0, in_data=8'h5A -> out_data=8'h5A, carry=0, latency 1.
REQ-033 SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_data/out_valid stable, in_ready=0, new in_valid ignored.
REQ-034 SHALL cover: rst pulsed mid-SHIFT (LSR, amt=7) -> next cycle in_ready=1, out_valid=0, out_data=0; a subsequent command completes correctly.
